// File: rtl/regfile_seq.sv
// Sequencer for an external 8x8 register file: runs NOP, CLEAR, SWAP and INC
// commands over read ports Ra/Rb and a single write port Wd/Wdat/Wen.
module regfile_seq (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Start,
  input  logic [1:0] Op,
  input  logic [2:0] SrcA,
  input  logic [2:0] SrcB,
  input  logic [7:0] RdatA,
  input  logic [7:0] RdatB,
  output logic [2:0] Ra,
  output logic [2:0] Rb,
  output logic [2:0] Wd,
  output logic [7:0] Wdat,
  output logic       Wen,
  output logic       Busy,
  output logic       Done,
  output logic       Carry
);

  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_CLEAR = 2'b01;
  localparam logic [1:0] OP_SWAP  = 2'b10;
  localparam logic [1:0] OP_INC   = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLR    = 3'd1,
    S_SW_RD  = 3'd2,
    S_SW_WA  = 3'd3,
    S_SW_WB  = 3'd4,
    S_INC_WR = 3'd5,
    S_DONE   = 3'd6
  } state_e;

  state_e     state_q;
  logic [1:0] op_q;
  logic [2:0] a_q;
  logic [2:0] b_q;
  logic [2:0] cnt_q;
  logic [7:0] ta_q;
  logic [7:0] tb_q;
  logic       carry_q;

  // Command FSM; operands are latched only on acceptance in IDLE, unused encoding falls back to IDLE.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= S_IDLE;
      op_q    <= 2'b00;
      a_q     <= 3'd0;
      b_q     <= 3'd0;
      cnt_q   <= 3'd0;
      ta_q    <= 8'd0;
      tb_q    <= 8'd0;
      carry_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (Start) begin
            op_q  <= Op;
            a_q   <= SrcA;
            b_q   <= SrcB;
            cnt_q <= 3'd0;
            case (Op)
              OP_NOP:   state_q <= S_DONE;
              OP_CLEAR: state_q <= S_CLR;
              OP_SWAP:  state_q <= S_SW_RD;
              OP_INC: begin
                state_q <= S_INC_WR;
                carry_q <= 1'b0;
              end
              default:  state_q <= S_IDLE;
            endcase
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_CLR: begin
          cnt_q <= cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            state_q <= S_DONE;
          end else begin
            state_q <= S_CLR;
          end
        end
        S_SW_RD: begin
          ta_q <= RdatA;
          tb_q <= RdatB;
          if (a_q == b_q) begin
            state_q <= S_DONE;
          end else begin
            state_q <= S_SW_WA;
          end
        end
        S_SW_WA: state_q <= S_SW_WB;
        S_SW_WB: state_q <= S_DONE;
        S_INC_WR: begin
          if ((op_q == OP_INC) && (RdatA == 8'hFF)) begin
            carry_q <= 1'b1;
          end else begin
            carry_q <= carry_q;
          end
          state_q <= S_DONE;
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign Ra    = a_q;
  assign Rb    = b_q;
  assign Carry = carry_q;

  // Moore decode of the write port and status; INC write data follows the live read port A.
  always_comb begin
    Wen  = 1'b0;
    Wd   = 3'd0;
    Wdat = 8'd0;
    Busy = 1'b0;
    Done = 1'b0;
    case (state_q)
      S_IDLE: begin
        Busy = 1'b0;
      end
      S_CLR: begin
        Wen  = 1'b1;
        Wd   = cnt_q;
        Busy = 1'b1;
      end
      S_SW_RD: begin
        Busy = 1'b1;
      end
      S_SW_WA: begin
        Wen  = 1'b1;
        Wd   = a_q;
        Wdat = tb_q;
        Busy = 1'b1;
      end
      S_SW_WB: begin
        Wen  = 1'b1;
        Wd   = b_q;
        Wdat = ta_q;
        Busy = 1'b1;
      end
      S_INC_WR: begin
        Wen  = 1'b1;
        Wd   = a_q;
        Wdat = RdatA + 8'd1;
        Busy = 1'b1;
      end
      S_DONE: begin
        Done = 1'b1;
      end
      default: begin
        Busy = 1'b0;
      end
    endcase
  end

endmodule

// File: doc/regfile_seq.md
REGFILE_SEQ -- requirements
Module: regfile_seq

Interface
REQ-001 SHALL have port Clk, input, 1, the single clock; all state updates on posedge Clk.
REQ-002 SHALL have port Reset, input, 1, synchronous active-high reset, sampled on posedge Clk.
REQ-003 SHALL have port Start, input, 1, command request; sampled only in IDLE.
REQ-004 SHALL have port Op, input, 2, command code: 00 NOP, 01 CLEAR, 10 SWAP, 11 INC.
REQ-005 SHALL have port SrcA, input, 3, first register operand.
REQ-006 SHALL have port SrcB, input, 3, second register operand.
REQ-007 SHALL have port RdatA, input, 8, register file read data for Ra.
REQ-008 SHALL have port RdatB, input, 8, register file read data for Rb.
REQ-009 SHALL have port Ra, output, 3, register file read pointer A.
REQ-010 SHALL have port Rb, output, 3, register file read pointer B.
REQ-011 SHALL have port Wd, output, 3, register file write pointer.
REQ-012 SHALL have port Wdat, output, 8, register file write data.
REQ-013 SHALL have port Wen, output, 1, register file write enable.
REQ-014 SHALL have port Busy, output, 1, high while a command executes.
REQ-015 SHALL have port Done, output, 1, one-cycle completion pulse.
REQ-016 SHALL have port Carry, output, 1, sticky INC wrap flag.

Function
REQ-017 SHALL implement states IDLE, CLR, SW_RD, SW_WA, SW_WB, INC_WR and DONE.
REQ-018 In IDLE with Start=1, SHALL latch Op/SrcA/SrcB into opR/aR/bR at the edge and go to: NOP->DONE, CLEAR->CLR, SWAP->SW_RD, INC->INC_WR.
REQ-019 SHALL ignore Start in every state other than IDLE; operands are never re-latched mid-command.
REQ-020 SHALL drive Ra=aR and Rb=bR at all times.
REQ-021 SHALL drive Wen, Wd and Wdat as Moore outputs of state and registers; Wen=0, Wd=0, Wdat=0 unless stated below.
REQ-022 In CLR, SHALL assert Wen=1, Wd=cnt, Wdat=0, with 3-bit cnt starting at 0 and incrementing each cycle.
REQ-023 SHALL leave CLR for DONE on the cycle with cnt=7: exactly 8 writes, registers 0..7 in order.
REQ-024 In SW_RD, SHALL hold Wen=0 and capture tA<=RdatA and tB<=RdatB at the end of the cycle.
REQ-025 From SW_RD, SHALL go to DONE if aR==bR (no writes), else to SW_WA.
REQ-026 In SW_WA, SHALL assert Wen=1, Wd=aR, Wdat=tB, then go to SW_WB.
REQ-027 In SW_WB, SHALL assert Wen=1, Wd=bR, Wdat=tA, then go to DONE.
REQ-028 In INC_WR, SHALL assert Wen=1, Wd=aR, Wdat=(RdatA+1) mod 256, then go to DONE.
REQ-029 SHALL set Carry to 1 at the INC_WR edge when RdatA==8'hFF; Carry otherwise holds.
REQ-030 SHALL clear Carry only on Reset or on acceptance of a new INC.
REQ-031 In DONE, SHALL drive Done=1 and Busy=0, then go to IDLE; Done SHALL be 0 in all other states.
REQ-032 SHALL drive Busy=1 in CLR, SW_RD, SW_WA, SW_WB and INC_WR, and Busy=0 in IDLE and DONE.
REQ-033 Cycles from acceptance edge to Done SHALL be: NOP 1, INC 2, SWAP equal-operand 2, SWAP 4, CLEAR 9.
REQ-034 SHALL never assert Wen for more than one address per cycle and never in IDLE, SW_RD or DONE.
REQ-035 An illegal state encoding SHALL return to IDLE on the next edge.

Reset
REQ-036 On Reset=1 at a posedge, SHALL go to IDLE and clear opR, aR, bR, cnt, tA, tB and Carry; SHALL override Start.
REQ-037 After reset, outputs SHALL be Ra=0, Rb=0, Wd=0, Wdat=0, Wen=0, Busy=0, Done=0, Carry=0.
REQ-038 Reset mid-command SHALL abort on that edge: no further Wen and no Done pulse; registers already written keep their values.

Verification
REQ-039 CLEAR with all registers preloaded to 8'hAA -> Wen high 8 consecutive cycles, Wd 0..7, Wdat 0; Done at cycle 9; all registers 0.
REQ-040 SWAP SrcA=2 (8'h11), SrcB=5 (8'h22) -> writes core[2]=22 then core[5]=11; Done at cycle 4.
REQ-041 SWAP SrcA=SrcB=3 -> no Wen cycles; Done at cycle 2; core[3] unchanged.
REQ-042 INC core[1]=8'hFF -> core[1]=00 and Carry=1; next INC core[1]=00 -> 01 and Carry=0.
REQ-043 Reset asserted at CLR cycle 4 -> registers 0..3 zero, 4..7 unchanged, Done never pulses; Start held high during Busy is ignored.
REQ-044 NOP -> Done=1 on the cycle after acceptance, with no Wen cycles.
